// File: rtl/bcd2bin_seq.sv
// Sequential BCD-to-binary converter (reverse double-dabble, one shift per clock).
// Optional digit checking is enabled by defining BCD2BIN_CHK_EN.
module bcd2bin_seq #(
    parameter int unsigned DIGITS = 3,
    parameter int unsigned BIN_W  = 10
) (
    input  logic                  clk_50mHz,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic                  busy,
    output logic                  done,
    output logic [BIN_W-1:0]      bin_out,
    output logic                  err
);

    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

    typedef enum logic [1:0] {StIdle, StConv, StFin} state_e;

    state_e             state_q;
    logic [BCD_W-1:0]   bcd_q;
    logic [BIN_W-1:0]   bin_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [BCD_W-1:0]   bcd_step;
    logic [BIN_W-1:0]   bin_step;

    // One algorithm step: shift {bcd, bin} right, then pull each digit >= 8 down by 3.
    always_comb begin
        bin_step = {bcd_q[0], bin_q[BIN_W-1:1]};
        bcd_step = {1'b0, bcd_q[BCD_W-1:1]};
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_step[4*i +: 4] >= 4'd8) begin
                bcd_step[4*i +: 4] = bcd_step[4*i +: 4] - 4'd3;
            end
        end
    end

`ifdef BCD2BIN_CHK_EN
    logic bad_digit;
    logic chk_fail_q;
    logic err_q;

    always_comb begin
        bad_digit = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_in[4*i +: 4] > 4'd9) begin
                bad_digit = 1'b1;
            end
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk_50mHz or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            bcd_q      <= '0;
            bin_q      <= '0;
            cnt_q      <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            bin_out    <= '0;
`ifdef BCD2BIN_CHK_EN
            chk_fail_q <= 1'b0;
            err_q      <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start) begin
                        bcd_q <= bcd_in;
                        bin_q <= '0;
                        cnt_q <= '0;
                        busy  <= 1'b1;
`ifdef BCD2BIN_CHK_EN
                        chk_fail_q <= bad_digit;
                        state_q    <= bad_digit ? StFin : StConv;
`else
                        state_q <= StConv;
`endif
                    end
                end
                StConv: begin
                    bcd_q <= bcd_step;
                    bin_q <= bin_step;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        state_q <= StFin;
                    end
                end
                StFin: begin
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    state_q <= StIdle;
`ifdef BCD2BIN_CHK_EN
                    bin_out <= chk_fail_q ? '0 : bin_q;
                    err_q   <= chk_fail_q;
`else
                    bin_out <= bin_q;
`endif
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd2bin_seq.sv
// Scoreboard bench for bcd2bin_seq: stimulus pushes expected results, a monitor checks each done.
module tb_bcd2bin_seq;

    localparam int LAT = 11;

    logic        clk_50mHz = 1'b0;
    logic        rst_n     = 1'b0;
    logic        start     = 1'b0;
    logic [11:0] bcd_in    = '0;
    logic        busy;
    logic        done;
    logic [9:0]  bin_out;
    logic        err;

    typedef struct {
        logic [9:0] bin;
        logic       err;
        int         cyc;
        bit         dc;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    logic prev_done = 1'b0;

    bcd2bin_seq #(.DIGITS(3), .BIN_W(10)) dut (
        .clk_50mHz (clk_50mHz),
        .rst_n     (rst_n),
        .start     (start),
        .bcd_in    (bcd_in),
        .busy      (busy),
        .done      (done),
        .bin_out   (bin_out),
        .err       (err)
    );

    always #10 clk_50mHz = ~clk_50mHz;
    always @(posedge clk_50mHz) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk_50mHz) begin
        if (rst_n && done) begin
            check("done_one_cycle", {31'd0, prev_done}, 0);
            if (sb.size() == 0) begin
                check("spurious_done", {31'd0, done}, 0);
            end else begin
                automatic exp_t e = sb.pop_front();
                if (!e.dc) check("bin_out", {22'd0, bin_out}, {22'd0, e.bin});
                check("err", {31'd0, err}, {31'd0, e.err});
                check("latency", cyc, e.cyc);
                check("busy_at_done", {31'd0, busy}, 0);
            end
        end
        prev_done <= done;
    end

    // Called at a negedge; start is accepted on the following posedge.
    task automatic issue(input logic [11:0] v, input logic [9:0] eb, input logic ee,
                         input int lat, input bit dc);
        bcd_in = v;
        start  = 1'b1;
        @(negedge clk_50mHz);
        start  = 1'b0;
        sb.push_back('{eb, ee, cyc + lat, dc});
        check("busy_after_start", {31'd0, busy}, 1);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(negedge clk_50mHz);
            n++;
        end
        check("drain_timeout", sb.size(), 0);
    endtask

    initial begin
        #100us;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nd;
        int n;
        #1;
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_done", {31'd0, done}, 0);
        check("rst_bin", {22'd0, bin_out}, 0);
        check("rst_err", {31'd0, err}, 0);
        repeat (2) @(negedge clk_50mHz);
        rst_n = 1'b1;
        @(negedge clk_50mHz);

        issue(12'h255, 10'd255, 1'b0, LAT, 1'b0);
        drain();
        issue(12'h999, 10'd999, 1'b0, LAT, 1'b0);
        drain();
        issue(12'h000, 10'd0, 1'b0, LAT, 1'b0);
        drain();

`ifdef BCD2BIN_CHK_EN
        issue(12'h1A3, 10'd0, 1'b1, 1, 1'b0);
`else
        issue(12'h1A3, 10'd0, 1'b0, LAT, 1'b1);
`endif
        drain();

        // Second start while busy must be dropped.
        issue(12'h042, 10'd42, 1'b0, LAT, 1'b0);
        repeat (2) @(negedge clk_50mHz);
        bcd_in = 12'h777;
        start  = 1'b1;
        @(negedge clk_50mHz);
        start  = 1'b0;
        drain();
        repeat (15) @(negedge clk_50mHz);

        // Back-to-back: start issued in the done cycle.
        issue(12'h128, 10'd128, 1'b0, LAT, 1'b0);
        n = 0;
        while (!done && n < 40) begin
            @(negedge clk_50mHz);
            n++;
        end
        check("done_seen_128", {31'd0, done}, 1);
        issue(12'h064, 10'd64, 1'b0, LAT, 1'b0);
        drain();

        // Reset mid-conversion discards the request.
        bcd_in = 12'h500;
        start  = 1'b1;
        @(negedge clk_50mHz);
        start  = 1'b0;
        repeat (5) @(negedge clk_50mHz);
        sb.delete();
        rst_n = 1'b0;
        #1;
        check("arst_busy", {31'd0, busy}, 0);
        check("arst_done", {31'd0, done}, 0);
        check("arst_bin", {22'd0, bin_out}, 0);
        check("arst_err", {31'd0, err}, 0);
        @(negedge clk_50mHz);
        rst_n = 1'b1;
        nd = 0;
        repeat (20) begin
            @(negedge clk_50mHz);
            if (done) nd++;
        end
        check("no_done_after_reset", nd, 0);

        issue(12'h314, 10'd314, 1'b0, LAT, 1'b0);
        drain();
        repeat (3) @(negedge clk_50mHz);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
